uart_alu_top: RTL and testbench
===============================

// Module: uart_alu_top
// PURPOSE
//  FPGA top level of the iCE40 UART ALU. Receives 8N1 serial command frames on tx_i and executes
//  one 8-bit ALU operation per frame. Returns each result as a single 8N1 byte on data_o.
//  The host drives tx_i from its UART transmitter (the codebase uart_tx, same PRESCALE).
// PARAMETERS
//  DATA_WIDTH  8   UART data bits and ALU operand/result width
//  PRESCALE    13  bit period = 8*PRESCALE clk_i cycles (uart_tx prescale convention)
// PORTS
//  clk_i   in   1  single clock; all logic on its rising edge
//  rst     in   1  reset, synchronous, active-high
//  tx_i    in   1  serial input (host TX line); idle high, asynchronous to clk_i
//  data_o  out  1  serial result output; idle high
// BEHAVIOUR
//  Reset
//   - While rst=1 on a clk_i edge: data_o=1, RX idle, byte counter=0, result-pending flag=0.
//   - Reset mid-frame or mid-transmit aborts the frame or transmit; no partial byte is emitted.
//  RX (8N1, LSB first)
//   - tx_i passes through a 2-flop synchronizer.
//   - Start is detected on a synchronized 1->0 edge while idle.
//   - Mid-bit recheck at 4*PRESCALE cycles: if the line is 1, the start is treated as a glitch -> idle.
//   - Data bits are sampled every 8*PRESCALE cycles at mid-bit. The stop bit is sampled the same way.
//   - Stop=1: byte valid, pulsed for 1 cycle. Stop=0: framing error; byte dropped; frame counter reset to 0.
//     RX then waits for the line to be high before rearming.
//  Frame assembly: states IDLE(0)->GOT_OP(1)->GOT_A(2)->EXEC. Frame bytes are [opcode, a, b].
//  ALU (result is the low DATA_WIDTH bits; no flags are transmitted)
//   - 0x00 PASS: a.
//   - 0x01 ADD: a+b, wraps mod 256.
//   - 0x02 SUB: a-b, two's-complement wrap.
//   - 0x03 AND. 0x04 OR. 0x05 XOR.
//   - 0x06 SHL: a<<b[2:0]. 0x07 SHR: a>>b[2:0], logical.
//   - Any other opcode: result 0xFF.
//  TX
//   - The result is loaded into a 1-entry holding register within 2 cycles of the valid pulse for byte b.
//   - It is presented to uart_tx with tvalid and held until tready=1.
//   - The start bit appears on data_o at most 2 cycles after acceptance.
//   - RX keeps accepting new frames while TX is busy.
//   - If a new result arrives while the holding register is still full, the new result overwrites it.
//     This cannot occur at matched baud, since 3 bytes in take longer than 1 byte out.
//   - Back-to-back frames produce back-to-back result bytes in order.
// STRUCTURE
//  - Package uart_alu_pkg holds:
//    - typedef enum logic [7:0] alu_op_e, with the opcodes above;
//    - localparam ERR_RESULT = 8'hFF;
//    - frame state typedef.
//  - New sub-module uart_rx: params DATA_WIDTH; ports clk, rst, rxd, prescale, m_axis_tdata, m_axis_tvalid,
//    frame_error. Its handshake mirrors the existing uart_tx.
//  - uart_alu_top instantiates uart_rx, the frame FSM and ALU (combinational case on alu_op_e),
//    and the existing uart_tx, with prescale tied to PRESCALE.
// TESTING (bench drives tx_i from uart_tx at PRESCALE=13 and decodes data_o with a UART receiver model)
//  - rst held 5 cycles -> data_o=1 throughout; no traffic on data_o until a frame completes.
//  - Send 0x01,0x05,0x03 -> one byte 0x08 on data_o. Send 0x02,0x03,0x05 -> 0xFE.
//  - Send 0x03,0xF0,0x3C -> 0x30. Send 0x01,0xFF,0x02 -> 0x01 (wrap). Send 0x07,0x80,0x03 -> 0x10.
//  - Send opcode 0x7E,0x11,0x22 -> 0xFF.
//  - Framing error: send 0x01 with stop bit forced 0, then 0x01,0x02,0x03 -> exactly one byte, 0x05.
//  - Send 0x01,0x05, assert rst 1 cycle, then 0x04,0x0F,0xF0 -> only 0xFF. No stale result; 3 frames back-to-back.
//  - Check results emerge in order.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU: opcode encoding, error result
// and the frame-assembly state encoding.
package uart_alu_pkg;

  typedef enum logic [7:0] {
    OP_PASS = 8'h00,
    OP_ADD  = 8'h01,
    OP_SUB  = 8'h02,
    OP_AND  = 8'h03,
    OP_OR   = 8'h04,
    OP_XOR  = 8'h05,
    OP_SHL  = 8'h06,
    OP_SHR  = 8'h07
  } alu_op_e;

  localparam logic [7:0] ERR_RESULT = 8'hFF;

  // Frame position: how many bytes of [opcode, a, b] have been received,
  // plus a one-cycle execute step once b is in.
  typedef logic [1:0] frame_state_t;
  localparam frame_state_t FS_IDLE   = 2'd0;
  localparam frame_state_t FS_GOT_OP = 2'd1;
  localparam frame_state_t FS_GOT_A  = 2'd2;
  localparam frame_state_t FS_EXEC   = 2'd3;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. Bit period is 8*prescale clocks; the start
// bit is rechecked at its middle and every later bit is sampled mid-bit.
// A bad stop bit raises frame_error for one cycle and the receiver waits for
// the line to return high before looking for the next start edge.
module uart_rx
  import uart_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  frame_error
);

  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  logic                  sync1_q, sync2_q, prev_q;
  logic [2:0]            state_q, state_d;
  logic [18:0]           cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic [18:0]           full_s, half_s;

  assign full_s = {prescale, 3'b000} - 19'd1;
  assign half_s = {1'b0, prescale, 2'b00} - 19'd1;

  // Receiver next-state: start detect, mid-bit sampling, stop check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tdata_d = tdata_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = half_s;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_q != 19'd0) begin
          cnt_d = cnt_q - 19'd1;
        end else if (!sync2_q) begin
          state_d = RX_DATA;
          cnt_d   = full_s;
          bit_d   = '0;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt_q != 19'd0) begin
          cnt_d = cnt_q - 19'd1;
        end else begin
          shreg_d = {sync2_q, shreg_q[DATA_WIDTH-1:1]};
          cnt_d   = full_s;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      RX_STOP: begin
        if (cnt_q != 19'd0) begin
          cnt_d = cnt_q - 19'd1;
        end else if (sync2_q) begin
          tdata_d = shreg_q;
          valid_d = 1'b1;
          state_d = RX_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (sync2_q) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_WAIT;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Synchronizer and receiver state registers; the line is assumed idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= 19'd0;
      bit_q   <= '0;
      shreg_q <= '0;
      tdata_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tdata_q <= tdata_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = valid_q;
  assign frame_error   = ferr_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, bit period 8*prescale clocks. Accepts a
// byte on the valid/ready handshake and drives the start bit on the next edge.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  input  logic [15:0]           prescale
);

  localparam int CW = $clog2(DATA_WIDTH + 2);

  logic                tready_q, tready_d;
  logic                busy_q, busy_d;
  logic                txd_q, txd_d;
  logic [DATA_WIDTH:0] sh_q, sh_d;
  logic [CW-1:0]       bit_q, bit_d;
  logic [18:0]         cnt_q, cnt_d;
  logic [18:0]         full_s;

  assign full_s = {prescale, 3'b000} - 19'd1;

  // Transmitter next-state: accept, then shift out data bits and stop bit.
  always_comb begin
    tready_d = tready_q;
    busy_d   = busy_q;
    txd_d    = txd_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    if (!busy_q) begin
      if (s_axis_tvalid && tready_q) begin
        tready_d = 1'b0;
        busy_d   = 1'b1;
        txd_d    = 1'b0;
        sh_d     = {1'b1, s_axis_tdata};
        bit_d    = CW'(DATA_WIDTH + 1);
        cnt_d    = full_s;
      end else begin
        tready_d = 1'b1;
      end
    end else if (cnt_q != 19'd0) begin
      cnt_d = cnt_q - 19'd1;
    end else if (bit_q != '0) begin
      txd_d = sh_q[0];
      sh_d  = {1'b1, sh_q[DATA_WIDTH:1]};
      bit_d = bit_q - CW'(1);
      cnt_d = full_s;
    end else begin
      busy_d   = 1'b0;
      tready_d = 1'b1;
    end
  end

  // Transmitter registers; line idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      txd_q    <= 1'b1;
      sh_q     <= '1;
      bit_q    <= '0;
      cnt_q    <= 19'd0;
    end else begin
      tready_q <= tready_d;
      busy_q   <= busy_d;
      txd_q    <= txd_d;
      sh_q     <= sh_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign txd           = txd_q;

endmodule

// File: rtl/uart_alu_top.sv
// UART ALU top: three received bytes [opcode, a, b] form one command; the
// 8-bit result is parked in a one-entry holding register and sent back as a
// single UART byte. A newer result overwrites an unsent one.
module uart_alu_top
  import uart_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 13
) (
  input  logic clk_i,
  input  logic rst,
  input  logic tx_i,
  output logic data_o
);

  localparam logic [15:0] PRESCALE_W = 16'(PRESCALE);

  logic [DATA_WIDTH-1:0] rx_data_s;
  logic                  rx_valid_s;
  logic                  rx_ferr_s;
  logic                  tx_ready_s;

  frame_state_t          fs_q, fs_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] alu_res_s;

  uart_rx #(.DATA_WIDTH(DATA_WIDTH)) u_rx (
    .clk           (clk_i),
    .rst           (rst),
    .rxd           (tx_i),
    .prescale      (PRESCALE_W),
    .m_axis_tdata  (rx_data_s),
    .m_axis_tvalid (rx_valid_s),
    .frame_error   (rx_ferr_s)
  );

  // Frame assembly: collect opcode, a, b; a framing error restarts the frame.
  always_comb begin
    fs_d = fs_q;
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    case (fs_q)
      FS_IDLE: begin
        if (rx_valid_s) begin
          op_d = rx_data_s;
          fs_d = FS_GOT_OP;
        end else begin
          fs_d = FS_IDLE;
        end
      end
      FS_GOT_OP: begin
        if (rx_valid_s) begin
          a_d  = rx_data_s;
          fs_d = FS_GOT_A;
        end else begin
          fs_d = FS_GOT_OP;
        end
      end
      FS_GOT_A: begin
        if (rx_valid_s) begin
          b_d  = rx_data_s;
          fs_d = FS_EXEC;
        end else begin
          fs_d = FS_GOT_A;
        end
      end
      FS_EXEC: fs_d = FS_IDLE;
      default: fs_d = FS_IDLE;
    endcase
    if (rx_ferr_s) begin
      fs_d = FS_IDLE;
    end else begin
      fs_d = fs_d;
    end
  end

  // ALU: result of the captured command; unknown opcodes give ERR_RESULT.
  always_comb begin
    alu_res_s = ERR_RESULT;
    case (alu_op_e'(op_q))
      OP_PASS: alu_res_s = a_q;
      OP_ADD:  alu_res_s = a_q + b_q;
      OP_SUB:  alu_res_s = a_q - b_q;
      OP_AND:  alu_res_s = a_q & b_q;
      OP_OR:   alu_res_s = a_q | b_q;
      OP_XOR:  alu_res_s = a_q ^ b_q;
      OP_SHL:  alu_res_s = a_q << b_q[2:0];
      OP_SHR:  alu_res_s = a_q >> b_q[2:0];
      default: alu_res_s = ERR_RESULT;
    endcase
  end

  // Holding register: a fresh result wins over the transmitter draining it.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (fs_q == FS_EXEC) begin
      hold_d       = alu_res_s;
      hold_valid_d = 1'b1;
    end else if (hold_valid_q && tx_ready_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
  end

  // Frame and holding registers; reset drops any partial frame or pending result.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      fs_q         <= FS_IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      fs_q         <= fs_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  uart_tx #(.DATA_WIDTH(DATA_WIDTH)) u_tx (
    .clk           (clk_i),
    .rst           (rst),
    .s_axis_tdata  (hold_q),
    .s_axis_tvalid (hold_valid_q),
    .s_axis_tready (tx_ready_s),
    .txd           (data_o),
    .prescale      (PRESCALE_W)
  );

endmodule

// File: tb/tb_uart_alu_top.sv
// Bench for uart_alu_top: bit-bangs 8N1 frames into tx_i, decodes data_o
// with a UART receiver model and compares the decoded bytes, in order,
// against results predicted from the command bytes sent.
module tb_uart_alu_top;

  localparam int PRESCALE = 13;
  localparam int BIT_CYC  = 8 * PRESCALE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_line = 1'b1;
  logic data_line;

  int n_total = 0;
  int n_bad   = 0;
  int mon_err = 0;
  bit mon_en  = 1'b0;

  int rxq[$];
  int expq[$];
  int part[$];

  uart_alu_top #(.DATA_WIDTH(8), .PRESCALE(PRESCALE)) dut (
    .clk_i  (clk),
    .rst    (rst),
    .tx_i   (tx_line),
    .data_o (data_line)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the opcode table, in plain arithmetic.
  function automatic int ref_alu(input int op, input int a, input int b);
    int s;
    s = b % 8;
    case (op)
      0: return a;
      1: return (a + b) % 256;
      2: return (a - b + 256) % 256;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      6: return (a * (1 << s)) % 256;
      7: return a / (1 << s);
      default: return 255;
    endcase
  endfunction

  // Model: bytes accumulate into a frame; every third good byte yields a result.
  task automatic model_byte(input int b, input bit stop_ok);
    if (!stop_ok) begin
      part.delete();
    end else begin
      part.push_back(b);
      if (part.size() == 3) begin
        expq.push_back(ref_alu(part[0], part[1], part[2]));
        part.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(int'(b), stop_ok);
    tx_line = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx_line = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    tx_line = stop_ok;
    repeat (BIT_CYC) @(negedge clk);
    if (!stop_ok) begin
      tx_line = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    send_byte(op, 1'b1);
    send_byte(a, 1'b1);
    send_byte(b, 1'b1);
  endtask

  // Receiver model on data_o: mid-bit sampling, stop bit must be high.
  initial begin
    logic [7:0] v;
    wait (mon_en);
    forever begin
      @(negedge data_line);
      repeat (BIT_CYC / 2) @(negedge clk);
      if (data_line !== 1'b0) mon_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CYC) @(negedge clk);
        v[i] = data_line;
      end
      repeat (BIT_CYC) @(negedge clk);
      if (data_line !== 1'b1) mon_err++;
      rxq.push_back(int'(v));
    end
  end

  // Watchdog keeps the run bounded whatever the DUT does.
  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    int op, a, b;
    // Reset: output idle high on every reset cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val($sformatf("reset_data_o[%0d]", i), int'(data_line), 1);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (300) @(negedge clk);
    check_val("idle_no_traffic", rxq.size(), 0);
    check_val("idle_data_o", int'(data_line), 1);

    // Directed commands.
    send_frame(8'h01, 8'h05, 8'h03);
    send_frame(8'h02, 8'h03, 8'h05);
    send_frame(8'h03, 8'hF0, 8'h3C);
    send_frame(8'h01, 8'hFF, 8'h02);
    send_frame(8'h07, 8'h80, 8'h03);
    send_frame(8'h7E, 8'h11, 8'h22);

    // Framing error drops the byte and restarts the frame.
    send_byte(8'h01, 1'b0);
    send_frame(8'h01, 8'h02, 8'h03);

    // Let the last result drain, then reset in the middle of a frame.
    repeat (1500) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'h05, 1'b1);
    rst = 1'b1;
    part.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    send_frame(8'h04, 8'h0F, 8'hF0);

    // Random commands, back to back, mostly valid opcodes.
    for (int k = 0; k < 8; k++) begin
      op = $urandom_range(0, 9);
      if (op > 7) op = $urandom_range(8, 255);
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      send_frame(8'(op), 8'(a), 8'(b));
    end

    // Wait (bounded) for every predicted result to come out.
    waited = 0;
    while (rxq.size() < expq.size() && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    repeat (300) @(negedge clk);

    check_val("result_count", rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      check_val($sformatf("result[%0d]", i), (i < rxq.size()) ? rxq[i] : -1, expq[i]);
    end
    check_val("line_format_errors", mon_err, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
